// File: rtl/uart_rx_tx_fifo.sv
// Circular byte FIFO between the UART receiver and transmitter in the echo path.
// Captures each new received byte and replays bytes in order through a start/busy handshake.
module uart_rx_tx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_ready,
    input  logic              i_tx_busy,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [1:0]        ready_sync;
    logic [1:0]        busy_sync;
    logic              ready_prev;
    logic              ready_s;
    logic              busy_s;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              overflow_evt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] mem [DEPTH];

    // Ready path resets high so a level already asserted at reset release is not a new byte.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ready_sync <= 2'b11;
            busy_sync  <= 2'b00;
            ready_prev <= 1'b1;
        end else begin
            ready_sync <= {ready_sync[0], i_rx_ready};
            busy_sync  <= {busy_sync[0], i_tx_busy};
            ready_prev <= ready_s;
        end
    end

    assign ready_s  = ready_sync[1];
    assign busy_s   = busy_sync[1];
    assign push_req = ready_s & ~ready_prev;

    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);
    assign o_count = count;

    assign pop          = (state == ST_IDLE) && !o_empty && !busy_s;
    assign push_ok      = push_req && (!o_full || pop);
    assign overflow_evt = push_req && o_full && !pop;

    // NOTE: the storage array has no reset; only locations already written are ever read.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                o_tx_data <= mem[rd_ptr];
            end
            if (push_ok && !pop) begin
                count <= count + (ADDR_W + 1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (ADDR_W + 1)'(1);
            end
            if (overflow_evt) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (pop)     state_next = ST_START;
            ST_START:     if (busy_s)  state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!busy_s) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decoded from state so an asynchronous reset drops the request at once.
    assign o_tx_start = (state == ST_START);

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Directed bench for uart_rx_tx_fifo with a simple transmitter model that
// answers o_tx_start with a delayed busy pulse and records every byte it is handed.
module tb_uart_rx_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    logic       force_busy;
    logic       model_busy;
    logic       model_en;
    int         model_delay;
    int         model_len;
    logic [7:0] sent_q[$];
    int         start_pulses;

    int checks;
    int errors;
    int base;
    int pulse_base;

    assign tx_busy = force_busy | model_busy;

    uart_rx_tx_fifo #(.ADDR_W(4), .DATA_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_ready (rx_ready),
        .i_tx_busy  (tx_busy),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_empty    (empty),
        .o_full     (full),
        .o_count    (count),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: sees a start request, raises busy after a delay, then drops it.
    initial begin
        model_busy   = 1'b0;
        start_pulses = 0;
        forever begin
            @(negedge clk);
            if (model_en && tx_start) begin
                sent_q.push_back(tx_data);
                start_pulses++;
                repeat (model_delay) @(negedge clk);
                model_busy = 1'b1;
                repeat (model_len) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input string tag, input int max_cycles);
        int n = 0;
        while (tx_start !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_start), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        rx_data     = 8'h00;
        rx_ready    = 1'b1;
        force_busy  = 1'b0;
        model_en    = 1'b0;
        model_delay = 2;
        model_len   = 5;

        // Reset values, then release with ready already high: no push.
        #1;
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rel_ready_count", 32'(count), 32'd0);
        check("rel_ready_empty", 32'(empty), 32'd1);
        check("rel_ready_start", 32'(tx_start), 32'd0);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte with latency: count at the third edge, start at the fourth.
        model_delay = 20;
        model_len   = 100;
        model_en    = 1'b1;
        base        = sent_q.size();
        rx_data     = 8'h41;
        rx_ready    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_start_not_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("single_start_rise", 32'(tx_start), 32'd1);
        check("single_tx_data", 32'(tx_data), 32'h41);
        check("single_count_after_pop", 32'(count), 32'd0);
        repeat (10) @(negedge clk);
        check("single_start_held", 32'(tx_start), 32'd1);
        repeat (140) @(negedge clk);
        check("single_start_done", 32'(tx_start), 32'd0);
        check("single_empty", 32'(empty), 32'd1);
        check("single_data_stable", 32'(tx_data), 32'h41);
        check("single_sent_n", 32'(sent_q.size() - base), 32'd1);
        check("single_sent_val", 32'(sent_q[base]), 32'h41);

        // Ordering with a slow transmitter.
        model_delay = 3;
        model_len   = 30;
        base        = sent_q.size();
        pulse_base  = start_pulses;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
        repeat (300) @(negedge clk);
        check("order_pulses", 32'(start_pulses - pulse_base), 32'd5);
        check("order_n", 32'(sent_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("order_%0d", i), 32'(sent_q[base + i]), 32'h30 + i);

        // Full and overflow with busy held high in IDLE.
        model_en   = 1'b0;
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("full_count16", 32'(count), 32'd16);
        check("full_flag", 32'(full), 32'd1);
        check("full_no_ovf_yet", 32'(overflow), 32'd0);
        check("busy_idle_no_start", 32'(tx_start), 32'd0);
        send_byte(8'h10);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        model_delay = 2;
        model_len   = 5;
        model_en    = 1'b1;
        base        = sent_q.size();
        force_busy  = 1'b0;
        repeat (400) @(negedge clk);
        check("ovf_drain_n", 32'(sent_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) check($sformatf("ovf_drain_%0d", i), 32'(sent_q[base + i]), 32'(i));
        check("ovf_drain_empty", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop while full.
        model_en = 1'b0;
        do_reset();
        check("reset_clears_ovf", 32'(overflow), 32'd0);
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h50 + i));
        check("sim_full_before", 32'(count), 32'd16);
        base       = sent_q.size();
        model_en   = 1'b1;
        rx_data    = 8'h60;
        rx_ready   = 1'b1;
        force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check("sim_count", 32'(count), 32'd16);
        check("sim_no_ovf", 32'(overflow), 32'd0);
        check("sim_start", 32'(tx_start), 32'd1);
        repeat (400) @(negedge clk);
        check("sim_drain_n", 32'(sent_q.size() - base), 32'd17);
        for (int i = 0; i < 16; i++) check($sformatf("sim_drain_%0d", i), 32'(sent_q[base + i]), 32'h50 + i);
        check("sim_last", 32'(sent_q[base + 16]), 32'h60);
        check("sim_ovf_after", 32'(overflow), 32'd0);

        // Forty bytes through the FIFO to exercise pointer wrap.
        model_delay = 1;
        model_len   = 3;
        base        = sent_q.size();
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(8'h80 + i));
            repeat (8) @(negedge clk);
        end
        repeat (200) @(negedge clk);
        check("wrap_n", 32'(sent_q.size() - base), 32'd40);
        for (int i = 0; i < 40; i++) check($sformatf("wrap_%0d", i), 32'(sent_q[base + i]), 32'h80 + i);
        check("wrap_no_ovf", 32'(overflow), 32'd0);
        check("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset while in START with three bytes left.
        model_en   = 1'b0;
        force_busy = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i));
        force_busy = 1'b0;
        wait_start("mid_wait_start", 20);
        check("mid_count3", 32'(count), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("mid_start_drop", 32'(tx_start), 32'd0);
        check("mid_count0", 32'(count), 32'd0);
        check("mid_empty", 32'(empty), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);
        model_delay = 2;
        model_len   = 5;
        model_en    = 1'b1;
        base        = sent_q.size();
        send_byte(8'hB1);
        send_byte(8'hB2);
        repeat (100) @(negedge clk);
        check("post_rst_n", 32'(sent_q.size() - base), 32'd2);
        check("post_rst_0", 32'(sent_q[base]), 32'hB1);
        check("post_rst_1", 32'(sent_q[base + 1]), 32'hB2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
